ov7670_reg_conf_seq: RTL

//  Upstream sequencer for i2c_sender: walks a fixed OV7670 register table and feeds one (id, reg_addr, reg_data) write at a time.

---
 rtl/ov7670_reg_conf_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ov7670_reg_conf_seq.sv
// rtl/ov7670_reg_conf_seq.sv - OV7670 register table sequencer feeding i2c_sender
// Walks a fixed {addr,data} table, paces SCCB writes, idles after COM7 reset, flags done/stall.
module ov7670_reg_conf_seq #(
    parameter logic [7:0]  DEV_ID        = 8'h42,
    parameter logic [15:0] XFER_WAIT     = 16'd9000,
    parameter logic [19:0] RESET_DELAY   = 20'd50000,
    parameter logic [15:0] TOKEN_TIMEOUT = 16'd16384
) (
    input  logic       ov7670_clk50,
    input  logic       reg_conf_rst,
    input  logic       restart,
    input  logic       i2c_token,
    output logic       i2c_send,
    output logic [7:0] id,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       conf_done,
    output logic       conf_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_XFER,
        DELAY,
        DONE,
        ERROR
    } state_t;

    localparam logic [15:0] ENTRY_DELAY = 16'hF0F0;
    localparam logic [15:0] ENTRY_END   = 16'hFFFF;
    localparam logic [19:0] XFER_LAST   = {4'd0, XFER_WAIT} - 20'd1;
    localparam logic [19:0] DELAY_LAST  = RESET_DELAY - 20'd1;
    localparam logic [19:0] TOKEN_LAST  = {4'd0, TOKEN_TIMEOUT} - 20'd1;

    state_t      state;
    logic [5:0]  idx;
    logic [19:0] cnt;
    logic [15:0] entry;
    logic [19:0] hold_last;

    assign id = DEV_ID;

    // Unlisted slots read as the end marker so a short table terminates cleanly.
    always_comb begin
        entry = ENTRY_END;
        case (idx)
            6'd0:    entry = 16'h1280;
            6'd1:    entry = ENTRY_DELAY;
            6'd2:    entry = 16'h1204;
            6'd3:    entry = 16'h1180;
            6'd4:    entry = 16'h0C00;
            6'd5:    entry = 16'h3E00;
            6'd6:    entry = 16'h40D0;
            6'd7:    entry = 16'h8C00;
            default: entry = ENTRY_END;
        endcase
    end

    assign hold_last = (state == DELAY) ? DELAY_LAST : XFER_LAST;

    always_ff @(posedge ov7670_clk50 or posedge reg_conf_rst) begin
        if (reg_conf_rst) begin
            state     <= IDLE;
            idx       <= 6'd0;
            cnt       <= 20'd0;
            i2c_send  <= 1'b0;
            reg_addr  <= 8'd0;
            reg_data  <= 8'd0;
            conf_done <= 1'b0;
            conf_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= LOAD;
                LOAD: begin
                    reg_addr <= entry[15:8];
                    reg_data <= entry[7:0];
                    cnt      <= 20'd0;
                    if (entry == ENTRY_END) begin
                        state     <= DONE;
                        conf_done <= 1'b1;
                    end else if (entry == ENTRY_DELAY) begin
                        state <= DELAY;
                    end else begin
                        state    <= SEND;
                        i2c_send <= 1'b1;
                    end
                end
                SEND: begin
                    // Dropping send on the token edge keeps the sender from accepting twice.
                    if (i2c_token) begin
                        i2c_send <= 1'b0;
                        cnt      <= 20'd0;
                        state    <= WAIT_XFER;
                    end else if (cnt == TOKEN_LAST) begin
                        i2c_send  <= 1'b0;
                        conf_err  <= 1'b1;
                        conf_done <= 1'b0;
                        state     <= ERROR;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                WAIT_XFER, DELAY: begin
                    if (cnt == hold_last) begin
                        if (idx == 6'd63) begin
                            conf_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= LOAD;
                        end
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                DONE, ERROR: begin
                    if (restart) begin
                        conf_done <= 1'b0;
                        conf_err  <= 1'b0;
                        idx       <= 6'd0;
                        state     <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
